// File: rtl/bootrom_arbiter_if.sv
// Bus bundle between the tile-side AHB3-Lite requesters, the boot ROM
// arbiter and the shared combinational boot ROM.
//   req_*  : NREQ requester ports, flattened per-port slices
//   rom_*  : single shared ROM access port
// master modport: requesters + ROM model side; slave modport: arbiter side.
interface bootrom_arbiter_if #(
  parameter int unsigned PLEN = 32,
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]      req_hsel_i;
  logic [NREQ*PLEN-1:0] req_haddr_i;
  logic [NREQ-1:0]      req_hwrite_i;
  logic [NREQ*2-1:0]    req_htrans_i;
  logic [NREQ*XLEN-1:0] req_hrdata_o;
  logic [NREQ-1:0]      req_hready_o;
  logic [NREQ-1:0]      req_hresp_o;
  logic                 rom_hsel_o;
  logic [PLEN-1:0]      rom_haddr_o;
  logic [XLEN-1:0]      rom_hrdata_i;

  modport master (
    output req_hsel_i, req_haddr_i, req_hwrite_i, req_htrans_i,
    input  req_hrdata_o, req_hready_o, req_hresp_o,
    input  rom_hsel_o, rom_haddr_o,
    output rom_hrdata_i
  );

  modport slave (
    input  req_hsel_i, req_haddr_i, req_hwrite_i, req_htrans_i,
    output req_hrdata_o, req_hready_o, req_hresp_o,
    output rom_hsel_o, rom_haddr_o,
    input  rom_hrdata_i
  );
endinterface

// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing one combinational boot ROM between NREQ
// AHB3-Lite requesters. Each captured transfer is stalled until granted;
// reads return registered ROM data with OKAY, writes get a two-cycle ERROR.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : bootrom_arbiter_if.slave (requester ports + ROM port)
module bootrom_arbiter #(
  parameter int unsigned PLEN = 32,
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  bootrom_arbiter_if.slave   bus
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [IDXW-1:0]      grant_q, grant_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      pending_q, pending_d;
  logic [NREQ-1:0]      pwrite_q, pwrite_d;
  logic [PLEN-1:0]      paddr_q [NREQ];
  logic [PLEN-1:0]      paddr_d [NREQ];
  logic [NREQ-1:0]      hready_q, hready_d;
  logic [NREQ-1:0]      hresp_q, hresp_d;
  logic [NREQ*XLEN-1:0] hrdata_q, hrdata_d;
  logic                 rom_hsel_q, rom_hsel_d;
  logic [PLEN-1:0]      rom_haddr_q, rom_haddr_d;

  logic                 found;
  logic [IDXW-1:0]      cand;
  logic [IDXW-1:0]      win;
  logic [NREQ-1:0]      htrans_lsb_unused;

  // Only htrans[1] (NONSEQ/SEQ) matters for capture.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      htrans_lsb_unused[i] = bus.req_htrans_i[2*i];
    end
  end

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pending_d   = pending_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    hrdata_d    = hrdata_q;
    rom_hsel_d  = 1'b0;
    rom_haddr_d = '0;
    hready_d    = '0;
    hresp_d     = '0;
    found       = 1'b0;
    cand        = '0;
    win         = '0;

    // Completion clears first so a same-edge new capture wins.
    if (state_q == S_RESP || state_q == S_ERR2) begin
      pending_d[grant_q] = 1'b0;
    end

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (hready_q[i] && bus.req_hsel_i[i] && bus.req_htrans_i[2*i+1]) begin
        pending_d[i] = 1'b1;
        paddr_d[i]   = bus.req_haddr_i[i*PLEN +: PLEN];
        pwrite_d[i]  = bus.req_hwrite_i[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        // Search ascends from rr_ptr, wrapping modulo NREQ.
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = IDXW'((32'(rr_ptr_q) + k) % NREQ);
          if (!found && pending_q[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          grant_d = win;
          if (pwrite_q[win]) begin
            state_d = S_ERR1;
          end else begin
            state_d     = S_READ;
            rom_hsel_d  = 1'b1;
            rom_haddr_d = paddr_q[win];
          end
        end
      end
      S_READ: begin
        hrdata_d[32'(grant_q)*XLEN +: XLEN] = bus.rom_hrdata_i;
        state_d = S_RESP;
      end
      S_RESP, S_ERR2: begin
        rr_ptr_d = IDXW'((32'(grant_q) + 32'd1) % NREQ);
        state_d  = S_IDLE;
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Per-port handshake outputs, precomputed from next-cycle state.
    for (int unsigned i = 0; i < NREQ; i++) begin
      hready_d[i] = !pending_d[i] ||
                    (grant_d == IDXW'(i) && (state_d == S_RESP || state_d == S_ERR2));
      hresp_d[i]  = (grant_d == IDXW'(i) && (state_d == S_ERR1 || state_d == S_ERR2));
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pending_q   <= '0;
      pwrite_q    <= '0;
      paddr_q     <= '{default: '0};
      hready_q    <= '1;
      hresp_q     <= '0;
      hrdata_q    <= '0;
      rom_hsel_q  <= 1'b0;
      rom_haddr_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      rom_hsel_q  <= rom_hsel_d;
      rom_haddr_q <= rom_haddr_d;
    end
  end

  assign bus.req_hready_o = hready_q;
  assign bus.req_hresp_o  = hresp_q;
  assign bus.req_hrdata_o = hrdata_q;
  assign bus.rom_hsel_o   = rom_hsel_q;
  assign bus.rom_haddr_o  = rom_haddr_q;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed, table-driven bench for bootrom_arbiter with NREQ=2. The ROM is
// modelled as word = 0xC0DE_0000 | haddr[7:2].
module tb_bootrom_arbiter;

  localparam logic [1:0]  N  = 2'b10;
  localparam logic [1:0]  I  = 2'b00;
  localparam logic [1:0]  B  = 2'b01;
  localparam logic [31:0] W0 = 32'hC0DE_0000;

  typedef struct {
    logic        rst;
    logic [1:0]  hsel;
    logic [1:0]  ht0;
    logic [1:0]  ht1;
    logic [1:0]  hw;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  e_rdy;
    logic [1:0]  e_resp;
    logic        e_rsel;
    logic [31:0] e_raddr;
    logic [1:0]  cr;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   step;
  int   p0_done;
  int   p1_done;
  vec_t vecs[$];

  bootrom_arbiter_if #(.PLEN(32), .XLEN(32), .NREQ(2)) bus ();

  bootrom_arbiter #(.PLEN(32), .XLEN(32), .NREQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_hrdata_i = W0 | 32'(bus.rom_haddr_o[7:2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t v(input logic r, input logic [1:0] hsel, input logic [1:0] ht0,
                             input logic [1:0] ht1, input logic [1:0] hw,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] erdy, input logic [1:0] eresp,
                             input logic ersel, input logic [31:0] eaddr,
                             input logic [1:0] cr, input logic [31:0] rd0,
                             input logic [31:0] rd1);
    vec_t t;
    t.rst = r; t.hsel = hsel; t.ht0 = ht0; t.ht1 = ht1; t.hw = hw;
    t.a0 = a0; t.a1 = a1; t.e_rdy = erdy; t.e_resp = eresp;
    t.e_rsel = ersel; t.e_raddr = eaddr; t.cr = cr; t.e_rd0 = rd0; t.e_rd1 = rd1;
    return t;
  endfunction

  // Cycle with no requester activity.
  function automatic vec_t vi(input logic [1:0] erdy, input logic [1:0] eresp,
                              input logic ersel, input logic [31:0] eaddr,
                              input logic [1:0] cr, input logic [31:0] rd0,
                              input logic [31:0] rd1);
    return v(1'b0, 2'b00, I, I, 2'b00, 32'h0, 32'h0, erdy, eresp, ersel, eaddr, cr, rd0, rd1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst              = t.rst;
    bus.req_hsel_i   = t.hsel;
    bus.req_htrans_i = {t.ht1, t.ht0};
    bus.req_hwrite_i = t.hw;
    bus.req_haddr_i  = {t.a1, t.a0};
  endtask

  // One cycle: drive inputs at the falling edge, then compare the
  // registered outputs that hold for this whole cycle.
  task automatic apply(input vec_t t);
    @(negedge clk);
    step++;
    drive(t);
    chk("hready", 32'(bus.req_hready_o), 32'(t.e_rdy));
    chk("hresp", 32'(bus.req_hresp_o), 32'(t.e_resp));
    chk("rom_hsel", 32'(bus.rom_hsel_o), 32'(t.e_rsel));
    if (t.e_rsel) chk("rom_haddr", bus.rom_haddr_o, t.e_raddr);
    if (t.cr[0]) chk("hrdata0", bus.req_hrdata_o[31:0], t.e_rd0);
    if (t.cr[1]) chk("hrdata1", bus.req_hrdata_o[63:32], t.e_rd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    step     = 0;
    drive(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    rst = 1'b1;

    // Contention from rr_ptr=0: port0 first (cycle 3), port1 at cycle 6.
    vecs.push_back(v(1'b0, 2'b11, N, N, 2'b00, 32'h04, 32'h0C, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b00, 2'b00, 1'b0, 32'h0,  2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b00, 2'b00, 1'b1, 32'h04, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b01, 2'b00, 1'b0, 32'h0,  2'b01, W0 | 32'd1, 32'h0));
    vecs.push_back(vi(2'b01, 2'b00, 1'b0, 32'h0,  2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b01, 2'b00, 1'b1, 32'h0C, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0,  2'b10, 32'h0, W0 | 32'd3));
    // Single read port0 @0x08: two wait states, word 2.
    vecs.push_back(v(1'b0, 2'b01, N, I, 2'b00, 32'h08, 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b10, 2'b00, 1'b0, 32'h0,  2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b10, 2'b00, 1'b1, 32'h08, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0,  2'b01, W0 | 32'd2, 32'h0));
    // Contention from rr_ptr=1: port1 first.
    vecs.push_back(v(1'b0, 2'b11, N, N, 2'b00, 32'h14, 32'h18, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b00, 2'b00, 1'b0, 32'h0,  2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b00, 2'b00, 1'b1, 32'h18, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b10, 2'b00, 1'b0, 32'h0,  2'b10, 32'h0, W0 | 32'd6));
    vecs.push_back(vi(2'b10, 2'b00, 1'b0, 32'h0,  2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b10, 2'b00, 1'b1, 32'h14, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0,  2'b01, W0 | 32'd5, 32'h0));
    // Write error on port1: ERR1 then ERR2, ROM never strobed.
    vecs.push_back(v(1'b0, 2'b10, I, N, 2'b10, 32'h0, 32'h10, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b01, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b01, 2'b10, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b10, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    // IDLE/BUSY selected and NONSEQ unselected: nothing captured.
    vecs.push_back(v(1'b0, 2'b11, I, B, 2'b00, 32'h20, 32'h24, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(v(1'b0, 2'b00, N, N, 2'b00, 32'h20, 32'h24, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    vecs.push_back(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(bus.req_hready_o), 32'h3);
    chk("rst_hresp", 32'(bus.req_hresp_o), 32'h0);
    chk("rst_rom_hsel", 32'(bus.rom_hsel_o), 32'h0);
    chk("rst_rom_haddr", bus.rom_haddr_o, 32'h0);
    chk("rst_hrdata_lo", bus.req_hrdata_o[31:0], 32'h0);
    chk("rst_hrdata_hi", bus.req_hrdata_o[63:32], 32'h0);
    rst = 1'b0;

    foreach (vecs[j]) apply(vecs[j]);

    // Back-to-back: rr_ptr=0, both request; port0 re-requests in its RESP.
    apply(v(1'b0, 2'b11, N, N, 2'b00, 32'h00, 32'h04, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(vi(2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(vi(2'b00, 2'b00, 1'b1, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(v(1'b0, 2'b01, N, I, 2'b00, 32'h08, 32'h0, 2'b01, 2'b00, 1'b0, 32'h0, 2'b01, W0, 32'h0));
    p0_done = -1;
    p1_done = -1;
    for (int c = 0; c < 20 && p0_done < 0; c++) begin
      @(negedge clk);
      step++;
      drive(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
      if (bus.req_hready_o[1] && p1_done < 0) begin
        p1_done = c;
        chk("b2b_rd1", bus.req_hrdata_o[63:32], W0 | 32'd1);
      end
      if (bus.req_hready_o[0] && p0_done < 0) begin
        p0_done = c;
        chk("b2b_rd0", bus.req_hrdata_o[31:0], W0 | 32'd2);
      end
    end
    chk("b2b_p1_cycle", 32'(p1_done), 32'd2);
    chk("b2b_p0_cycle", 32'(p0_done), 32'd5);

    // Reset asserted during READ drops the in-flight request.
    apply(v(1'b0, 2'b01, N, I, 2'b00, 32'h0C, 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(vi(2'b10, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(v(1'b1, 2'b00, I, I, 2'b00, 32'h0, 32'h0, 2'b10, 2'b00, 1'b1, 32'h0C, 2'b00, 32'h0, 32'h0));
    apply(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b11, 32'h0, 32'h0));
    chk("midrst_rom_haddr", bus.rom_haddr_o, 32'h0);
    apply(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));
    apply(vi(2'b11, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
